// File: rtl/layer_shift_pipe_if.sv
// Stream bundle between the read network, the layer shift pipeline and its consumer.
// The pipeline takes the slave view and its neighbours take the master view.
interface layer_shift_pipe_if #(
    parameter int Z  = 4,
    parameter int Q  = 6,
    parameter int DC = 6,
    parameter int TW = 6
);
    localparam int SW = $clog2(Z);

    logic                        in_valid;
    logic                        in_ready;
    logic [DC-1:0][Z-1:0][Q-1:0] app_in;
    logic [DC-1:0][SW-1:0]       shift_in;
    logic [DC-1:0]               mask_in;
    logic                        inv_in;
    logic [TW-1:0]               tag_in;

    logic                        out_valid;
    logic                        out_ready;
    logic [DC-1:0][Z-1:0][Q-1:0] app_out;
    logic [DC-1:0]               mask_out;
    logic [TW-1:0]               tag_out;

    modport slave (
        input  in_valid, app_in, shift_in, mask_in, inv_in, tag_in, out_ready,
        output in_ready, out_valid, app_out, mask_out, tag_out
    );

    modport master (
        output in_valid, app_in, shift_in, mask_in, inv_in, tag_in, out_ready,
        input  in_ready, out_valid, app_out, mask_out, tag_out
    );
endinterface

// File: rtl/layer_shift_pipe.sv
// Two-stage pipeline applying the per-block quasi-cyclic rotation (forward or inverse)
// to one layer of APP blocks, with valid/ready flow control and tag/mask pass-through.
module layer_shift_pipe #(
    parameter int Z  = 4,
    parameter int Q  = 6,
    parameter int DC = 6,
    parameter int TW = 6
) (
    input  logic              clk,
    input  logic              rst,
    layer_shift_pipe_if.slave bus
);
    localparam int SW = $clog2(Z);

    typedef logic [DC-1:0][Z-1:0][Q-1:0] app_t;
    typedef logic [DC-1:0][SW-1:0]       shift_t;

    logic          en1, en2;
    logic          v1, v2;
    app_t          d1, d2, rot;
    shift_t        e_next, e1;
    logic [DC-1:0] m1, m2;
    logic [TW-1:0] t1, t2;

    assign en2          = !v2 || bus.out_ready;
    assign en1          = !v1 || en2;
    assign bus.in_ready = en1;

    // Direction is folded into the effective shift here, so stage 1 never has to keep inv.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        e_next = '0;
        for (int i = 0; i < DC; i++) begin
            if (bus.inv_in)
                e_next[i] = SW'((Z - (int'(bus.shift_in[i]) % Z)) % Z);
            else
                e_next[i] = SW'(int'(bus.shift_in[i]) % Z);
        end
    end

    // Each output lane picks the source lane at (j + e) mod Z; masked blocks read as zero.
    always_comb begin
        rot = '0;
        for (int i = 0; i < DC; i++)
            for (int j = 0; j < Z; j++)
                for (int k = 0; k < Z; k++)
                    if (m1[i] && k == (j + int'(e1[i])) % Z)
                        rot[i][j] = d1[i][k];
    end

    // NOTE: sequential state uses non-blocking assignments so all stages update together.
    // NOTE: data registers are reset as well, because app/mask/tag outputs must read zero in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1 <= 1'b0;
            d1 <= '0;
            e1 <= '0;
            m1 <= '0;
            t1 <= '0;
        end else if (en1) begin
            v1 <= bus.in_valid;
            d1 <= bus.app_in;
            e1 <= e_next;
            m1 <= bus.mask_in;
            t1 <= bus.tag_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2 <= 1'b0;
            d2 <= '0;
            m2 <= '0;
            t2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            d2 <= rot;
            m2 <= m1;
            t2 <= t1;
        end
    end

    assign bus.out_valid = v2;
    assign bus.app_out   = d2;
    assign bus.mask_out  = m2;
    assign bus.tag_out   = t2;
endmodule

// File: tb/tb_layer_shift_pipe.sv
// Self-checking bench for layer_shift_pipe: vector table plus scoreboard for Z=4,
// hand-written sequences for latency, backpressure, reset mid-flight and a Z=5 instance.
`timescale 1ns/1ps
module tb_layer_shift_pipe;
    localparam int Q  = 6;
    localparam int DC = 6;
    localparam int TW = 6;
    localparam int NV = 12;

    typedef logic [3:0][Q-1:0]          blk4_t;
    typedef logic [DC-1:0][3:0][Q-1:0]  app4_t;
    typedef logic [DC-1:0][1:0]         sh4_t;
    typedef logic [4:0][Q-1:0]          blk5_t;

    typedef struct {
        app4_t         app;
        sh4_t          shift;
        logic [DC-1:0] mask;
        logic          inv;
        logic [TW-1:0] tag;
        app4_t         exp_app;
    } vec_t;

    typedef struct {
        app4_t         app;
        logic [DC-1:0] mask;
        logic [TW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    layer_shift_pipe_if #(.Z(4), .Q(Q), .DC(DC), .TW(TW)) bus4 ();
    layer_shift_pipe_if #(.Z(5), .Q(Q), .DC(DC), .TW(TW)) bus5 ();

    layer_shift_pipe #(.Z(4), .Q(Q), .DC(DC), .TW(TW)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    layer_shift_pipe #(.Z(5), .Q(Q), .DC(DC), .TW(TW)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   out_count = 0;
    exp_t sb[$];
    vec_t tbl[NV];
    vec_t bp[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic blk4_t mk4(input int a, input int b, input int c, input int d);
        blk4_t r;
        r[0] = Q'(a); r[1] = Q'(b); r[2] = Q'(c); r[3] = Q'(d);
        return r;
    endfunction

    function automatic blk5_t mk5(input int a, input int b, input int c, input int d, input int e);
        blk5_t r;
        r[0] = Q'(a); r[1] = Q'(b); r[2] = Q'(c); r[3] = Q'(d); r[4] = Q'(e);
        return r;
    endfunction

    function automatic app4_t rep4(input blk4_t b);
        app4_t r;
        for (int i = 0; i < DC; i++) r[i] = b;
        return r;
    endfunction

    // Reference: rotate left one lane at a time (forward) or right (inverse).
    function automatic app4_t model4(input app4_t app, input sh4_t sh, input logic [DC-1:0] m,
                                     input logic inv);
        app4_t r = '0;
        for (int i = 0; i < DC; i++) begin
            blk4_t b;
            int    n;
            b = app[i];
            n = int'(sh[i]) % 4;
            for (int k = 0; k < n; k++) begin
                if (!inv) b = {b[0], b[3:1]};
                else      b = {b[2:0], b[3]};
            end
            if (m[i]) r[i] = b;
        end
        return r;
    endfunction

    function automatic vec_t mkvec(input app4_t app, input int sh, input logic [DC-1:0] m,
                                   input logic inv, input int tag, input app4_t exp_app);
        vec_t v;
        v.app     = app;
        v.shift   = {DC{2'(sh)}};
        v.mask    = m;
        v.inv     = inv;
        v.tag     = TW'(tag);
        v.exp_app = exp_app;
        return v;
    endfunction

    function automatic vec_t rndvec(input int tag);
        vec_t v;
        for (int i = 0; i < DC; i++) begin
            for (int j = 0; j < 4; j++) v.app[i][j] = Q'($urandom);
            v.shift[i] = 2'($urandom);
        end
        v.mask    = DC'($urandom);
        v.inv     = 1'($urandom);
        v.tag     = TW'(tag);
        v.exp_app = model4(v.app, v.shift, v.mask, v.inv);
        return v;
    endfunction

    // Scoreboard monitor: pops on every output transfer, checks hold during stalls.
    always @(negedge clk) begin
        if (rst && bus4.out_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                out_count++;
                $display("FAIL spurious_beat: got tag %0d expected no beat", bus4.tag_out);
            end else if (bus4.out_ready) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_app",  bus4.app_out,  e.app);
                check("sb_mask", bus4.mask_out, e.mask);
                check("sb_tag",  bus4.tag_out,  e.tag);
                out_count++;
            end else begin
                check("stall_hold_tag", bus4.tag_out, sb[0].tag);
                check("stall_hold_app", bus4.app_out, sb[0].app);
            end
        end
    end

    task automatic drive4(input vec_t v);
        bus4.in_valid = 1'b1;
        bus4.app_in   = v.app;
        bus4.shift_in = v.shift;
        bus4.mask_in  = v.mask;
        bus4.inv_in   = v.inv;
        bus4.tag_in   = v.tag;
    endtask

    // Present a beat just after an edge; it transfers on the first edge with in_ready high.
    task automatic send4(input vec_t v, output int waits);
        logic rdy;
        logic done;
        waits = 0;
        done  = 1'b0;
        drive4(v);
        while (!done) begin
            @(negedge clk);
            rdy = bus4.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back('{app: v.exp_app, mask: v.mask, tag: v.tag});
                done = 1'b1;
            end else if (++waits > 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got no in_ready expected acceptance tag %0d", v.tag);
                done = 1'b1;
            end
        end
        bus4.in_valid = 1'b0;
    endtask

    task automatic drain4(input string name);
        int b = 0;
        while (sb.size() != 0 && b < 100) begin
            @(posedge clk);
            #1;
            b++;
        end
        check(name, sb.size(), 0);
    endtask

    task automatic run5(input blk5_t blk, input logic [2:0] sh, input logic inv, input int tag,
                        output blk5_t got);
        int b = 0;
        bus5.app_in   = {DC{blk}};
        bus5.shift_in = {DC{sh}};
        bus5.mask_in  = '1;
        bus5.inv_in   = inv;
        bus5.tag_in   = TW'(tag);
        bus5.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b0;
        while (!bus5.out_valid && b < 10) begin
            @(posedge clk);
            #1;
            b++;
        end
        check("z5_valid", bus5.out_valid, 1);
        check("z5_tag", bus5.tag_out, TW'(tag));
        got = bus5.app_out[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1);
    end

    initial begin
        int    w;
        int    idx;
        int    cnt;
        logic  rdy;
        blk5_t got5;

        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
        bus4.app_in = '0; bus4.shift_in = '0; bus4.mask_in = '0; bus4.inv_in = 1'b0; bus4.tag_in = '0;
        bus5.in_valid = 1'b0; bus5.out_ready = 1'b1;
        bus5.app_in = '0; bus5.shift_in = '0; bus5.mask_in = '0; bus5.inv_in = 1'b0; bus5.tag_in = '0;

        tbl[0] = mkvec(rep4(mk4(1, 2, 3, 4)), 1, 6'h3F, 1'b0, 1, rep4(mk4(2, 3, 4, 1)));
        tbl[1] = mkvec(rep4(mk4(1, 2, 3, 4)), 1, 6'h3F, 1'b1, 2, rep4(mk4(4, 1, 2, 3)));
        tbl[2] = mkvec(rep4(mk4(4, 1, 2, 3)), 1, 6'h3F, 1'b0, 3, rep4(mk4(1, 2, 3, 4)));
        tbl[3] = mkvec(rep4(mk4(1, 2, 3, 4)), 0, 6'b000011, 1'b0, 4, '0);
        tbl[3].exp_app[0] = mk4(1, 2, 3, 4);
        tbl[3].exp_app[1] = mk4(1, 2, 3, 4);
        tbl[4] = mkvec(rep4(mk4(1, 2, 3, 4)), 3, 6'h3F, 1'b0, 5, rep4(mk4(4, 1, 2, 3)));
        tbl[5] = mkvec(rep4(mk4(1, 2, 3, 4)), 0, 6'h3F, 1'b1, 6, rep4(mk4(1, 2, 3, 4)));
        for (int t = 6; t < NV; t++) tbl[t] = rndvec(t + 1);
        for (int k = 0; k < 5; k++) bp[k] = rndvec(k + 1);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_app_out",   bus4.app_out,   0);
        check("rst_mask_out",  bus4.mask_out,  0);
        check("rst_tag_out",   bus4.tag_out,   0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", bus4.in_ready, 1);

        // Latency: presented after edge N, transferred at N+1, visible after N+2
        send4(tbl[0], w);
        check("lat_wait", w, 0);
        @(negedge clk);
        check("lat_edge1", bus4.out_valid, 0);
        @(negedge clk);
        check("lat_edge2", bus4.out_valid, 1);
        @(posedge clk);
        #1;

        // Table vectors back to back: one accepted per cycle
        for (int t = 1; t < NV; t++) begin
            send4(tbl[t], w);
            check("tput_wait", w, 0);
        end
        drain4("tbl_drain");

        // Backpressure: out_ready low for 4 cycles
        bus4.out_ready = 1'b0;
        cnt = out_count;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive4(bp[idx]);
            @(negedge clk);
            rdy = bus4.in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                sb.push_back('{app: bp[idx].exp_app, mask: bp[idx].mask, tag: bp[idx].tag});
                idx++;
            end
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready_low", bus4.in_ready, 0);
        bus4.out_ready = 1'b1;
        #1;
        check("bp_in_ready_rise", bus4.in_ready, 1);
        while (idx < 5) begin
            send4(bp[idx], w);
            idx++;
        end
        drain4("bp_drain");
        check("bp_out_count", out_count - cnt, 5);

        // Non-power-of-2 lifting size: shift 6 acts as 1, inverse shift 7 acts as inverse 2
        run5(mk5(10, 11, 12, 13, 14), 3'd6, 1'b0, 9, got5);
        check("z5_fwd_mod", got5, mk5(11, 12, 13, 14, 10));
        run5(mk5(10, 11, 12, 13, 14), 3'd7, 1'b1, 10, got5);
        check("z5_inv_mod", got5, mk5(13, 14, 10, 11, 12));

        // Reset with two beats in flight
        bus4.out_ready = 1'b0;
        send4(rndvec(20), w);
        send4(rndvec(21), w);
        @(negedge clk);
        check("midrst_pre_valid", bus4.out_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("midrst_out_valid", bus4.out_valid, 0);
        check("midrst_tag_out",   bus4.tag_out,   0);
        check("midrst_app_out",   bus4.app_out,   0);
        sb.delete();
        cnt = out_count;
        @(negedge clk);
        rst = 1'b1;
        bus4.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_stale", out_count - cnt, 0);
        check("midrst_in_ready", bus4.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
